// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_resolve_unit: EX-stage branch compare, redirect PC, mispredict     |
// | flag and optional 2-bit BHT (enabled by BRANCH_PREDICTOR_EN).             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic            br_pred_taken,
  input  logic            stall,
  input  logic            kill,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_pred_taken,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic [XLEN-1:0] res_redirect_pc,
  output logic            res_illegal
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic            cmp_eq;
  logic            cmp_lt_s;
  logic            cmp_lt_u;
  logic            taken_d;
  logic            illegal_d;
  logic            pred_in;
  logic            mispred_d;
  logic            capture;
  logic [XLEN-1:0] redirect_d;

  assign cmp_eq   = (rs1_val == rs2_val);
  assign cmp_lt_s = ($signed(rs1_val) < $signed(rs2_val));
  assign cmp_lt_u = (rs1_val < rs2_val);

  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (br_funct3)
      3'b000:  taken_d = cmp_eq;
      3'b001:  taken_d = !cmp_eq;
      3'b100:  taken_d = cmp_lt_s;
      3'b101:  taken_d = !cmp_lt_s;
      3'b110:  taken_d = cmp_lt_u;
      3'b111:  taken_d = !cmp_lt_u;
      default: illegal_d = 1'b1;
    endcase
  end

  assign redirect_d = br_pc + (taken_d ? br_imm : PC_STEP);
  assign mispred_d  = !illegal_d && (taken_d != pred_in);
  assign capture    = br_valid && !stall && !kill;

  // kill beats stall for the valid bit; payload just holds
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid       <= 1'b0;
      res_taken       <= 1'b0;
      res_mispredict  <= 1'b0;
      res_illegal     <= 1'b0;
      res_redirect_pc <= '0;
    end else if (kill) begin
      res_valid <= 1'b0;
    end else if (!stall) begin
      res_valid <= br_valid;
      if (br_valid) begin
        res_taken       <= taken_d;
        res_mispredict  <= mispred_d;
        res_illegal     <= illegal_d;
        res_redirect_pc <= redirect_d;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_EN
  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           bht [BHT_N];
  logic [BHT_IDX_W-1:0] res_idx;
  logic [BHT_IDX_W-1:0] fetch_idx;
  logic                 train;
  logic                 unused_fetch_bits;

  assign pred_in           = br_pred_taken;
  assign fetch_idx         = fetch_pc[BHT_IDX_W+1:2];
  assign fetch_pred_taken  = bht[fetch_idx][1];
  assign train             = res_valid && !stall && !res_illegal;
  assign unused_fetch_bits = ^{fetch_pc[XLEN-1:BHT_IDX_W+2], fetch_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      res_idx <= '0;
    end else if (capture) begin
      res_idx <= br_pc[BHT_IDX_W+1:2];
    end
  end

  // Saturating counters; a same-index fetch read sees the pre-update value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (train) begin
      if (res_taken) begin
        if (bht[res_idx] != 2'b11) bht[res_idx] <= bht[res_idx] + 2'd1;
      end else begin
        if (bht[res_idx] != 2'b00) bht[res_idx] <= bht[res_idx] - 2'd1;
      end
    end
  end
`else
  logic unused_pred_inputs;

  assign pred_in            = 1'b0;
  assign fetch_pred_taken   = 1'b0;
  assign unused_pred_inputs = ^{fetch_pc, br_pred_taken};
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_resolve_unit: directed self-checking bench for the branch      |
// | resolve unit, in either BRANCH_PREDICTOR_EN build.  Revision: 1.0         |
// +--------------------------------------------------------------------------+
module tb_branch_resolve_unit;

`ifdef BRANCH_PREDICTOR_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_valid = 1'b0;
  logic [2:0]  br_funct3 = 3'b000;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_imm = '0;
  logic        br_pred_taken = 1'b0;
  logic        stall = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_pred_taken;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispredict;
  logic [31:0] res_redirect_pc;
  logic        res_illegal;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.XLEN(32), .BHT_IDX_W(6)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_funct3(br_funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .br_pc(br_pc), .br_imm(br_imm),
    .br_pred_taken(br_pred_taken), .stall(stall), .kill(kill),
    .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_redirect_pc(res_redirect_pc), .res_illegal(res_illegal)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    br_valid = 1'b1; br_funct3 = f3; rs1_val = a; rs2_val = b;
    br_pc = pc; br_imm = imm; br_pred_taken = pred;
  endtask

  task automatic idle;
    br_valid = 1'b0; br_funct3 = 3'b000; rs1_val = '0; rs2_val = '0;
    br_pc = '0; br_imm = '0; br_pred_taken = 1'b0;
  endtask

  // result bundle {valid, taken, mispredict, illegal, redirect}
  function automatic logic [35:0] res_bus();
    return {res_valid, res_taken, res_mispredict, res_illegal, res_redirect_pc};
  endfunction

  task automatic test_reset;
    rst = 1'b1; idle; step; step;
    checks++;
    if (res_bus() !== 36'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", res_bus(), 36'h0);
    end
    fetch_pc = 32'h40;
    checks++;
    if (fetch_pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_pred: got %b expected 0", fetch_pred_taken);
    end
    rst = 1'b0;
  endtask

  task automatic test_bge_equal;
    drive(3'b101, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0); step;
    checks++;
    if (res_bus() !== {4'b1110, 32'h120}) begin
      errors++; $display("FAIL bge_equal: got %h expected %h", res_bus(), {4'b1110, 32'h120});
    end
    idle; step;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL bge_valid_drop: got %b expected 0", res_valid);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, pc, imm;
    logic        pred, t, ill;
  } vec_t;

  task automatic test_compare_types;
    vec_t v [9];
    logic        m;
    logic [31:0] rd;
    logic [35:0] exp_bus;
    v[0] = '{3'b100, 32'h80000000, 32'h1, 32'h100, 32'h40, 1'b0, 1'b1, 1'b0};
    v[1] = '{3'b110, 32'h80000000, 32'h1, 32'h100, 32'h40, 1'b0, 1'b0, 1'b0};
    v[2] = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h200, 32'hFFFFFFF0, 1'b1, 1'b1, 1'b0};
    v[3] = '{3'b111, 32'h7, 32'h7, 32'h300, 32'h8, 1'b0, 1'b1, 1'b0};
    v[4] = '{3'b001, 32'h3, 32'h3, 32'h400, 32'h10, 1'b1, 1'b0, 1'b0};
    v[5] = '{3'b000, 32'h3, 32'h4, 32'h500, 32'h10, 1'b0, 1'b0, 1'b0};
    v[6] = '{3'b100, 32'h1, 32'h80000000, 32'h600, 32'h10, 1'b0, 1'b0, 1'b0};
    v[7] = '{3'b110, 32'h1, 32'h80000000, 32'h700, 32'h10, 1'b0, 1'b1, 1'b0};
    v[8] = '{3'b011, 32'h5, 32'h5, 32'h800, 32'h10, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      drive(v[i].f3, v[i].a, v[i].b, v[i].pc, v[i].imm, v[i].pred);
      step;
      rd = v[i].t ? v[i].pc + v[i].imm : v[i].pc + 32'd4;
      m  = v[i].ill ? 1'b0 : (PE ? (v[i].t != v[i].pred) : v[i].t);
      exp_bus = {1'b1, v[i].t, m, v[i].ill, rd};
      checks++;
      if (res_bus() !== exp_bus) begin
        errors++; $display("FAIL compare_vec%0d: got %h expected %h", i, res_bus(), exp_bus);
      end
    end
    idle; step;
  endtask

  task automatic test_wrap;
    drive(3'b000, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h8, 1'b0); step;
    checks++;
    if (res_bus() !== {4'b1000, 32'h0}) begin
      errors++; $display("FAIL wrap_not_taken: got %h expected %h", res_bus(), {4'b1000, 32'h0});
    end
    drive(3'b000, 32'h2, 32'h2, 32'hFFFFFFFC, 32'h8, 1'b1); step;
    checks++;
    if (res_bus() !== {3'b110, 1'b0, 32'h4} && res_bus() !== {2'b11, PE ? 1'b0 : 1'b1, 1'b0, 32'h4}) begin
      errors++; $display("FAIL wrap_taken: got %h expected %h", res_bus(), {2'b11, ~PE, 1'b0, 32'h4});
    end
    idle; step;
  endtask

  task automatic test_back_to_back;
    logic        outs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        exp_pred [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        m;
    logic [35:0] exp_bus;
    rst = 1'b1; idle; step; rst = 1'b0;
    fetch_pc = 32'h40;
    for (int i = 0; i < 5; i++) begin
      drive(3'b000, 32'h1, outs[i] ? 32'h1 : 32'h2, 32'h40, 32'h10, 1'b1);
      step;
      m = PE ? (outs[i] != 1'b1) : outs[i];
      exp_bus = {1'b1, outs[i], m, 1'b0, outs[i] ? 32'h50 : 32'h44};
      checks++;
      if (res_bus() !== exp_bus) begin
        errors++; $display("FAIL b2b_res%0d: got %h expected %h", i, res_bus(), exp_bus);
      end
      checks++;
      if (fetch_pred_taken !== (PE & exp_pred[i])) begin
        errors++; $display("FAIL b2b_pred%0d: got %b expected %b", i, fetch_pred_taken, PE & exp_pred[i]);
      end
    end
    idle; step;
    checks++;
    if (fetch_pred_taken !== (PE & exp_pred[5])) begin
      errors++; $display("FAIL b2b_pred5: got %b expected %b", fetch_pred_taken, PE & exp_pred[5]);
    end
  endtask

  task automatic test_stall_kill;
    logic [35:0] a_bus;
    logic [35:0] b_bus;
    rst = 1'b1; idle; step; rst = 1'b0;
    fetch_pc = 32'h40;
    a_bus = {1'b1, 1'b1, 1'b1, 1'b0, 32'h50};
    b_bus = {1'b1, 1'b0, 1'b0, 1'b0, 32'h84};
    drive(3'b000, 32'h1, 32'h1, 32'h40, 32'h10, 1'b0); step;
    checks++;
    if (res_bus() !== a_bus) begin
      errors++; $display("FAIL stall_first: got %h expected %h", res_bus(), a_bus);
    end
    stall = 1'b1;
    drive(3'b001, 32'h1, 32'h1, 32'h80, 32'h10, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if (res_bus() !== a_bus) begin
        errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, res_bus(), a_bus);
      end
      checks++;
      if (fetch_pred_taken !== 1'b0) begin
        errors++; $display("FAIL stall_no_train%0d: got %b expected 0", i, fetch_pred_taken);
      end
    end
    stall = 1'b0; step;
    checks++;
    if (res_bus() !== b_bus) begin
      errors++; $display("FAIL stall_release: got %h expected %h", res_bus(), b_bus);
    end
    checks++;
    if (fetch_pred_taken !== PE) begin
      errors++; $display("FAIL stall_trained: got %b expected %b", fetch_pred_taken, PE);
    end
    kill = 1'b1;
    drive(3'b000, 32'h1, 32'h1, 32'h40, 32'h10, 1'b0); step;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL kill_clear: got %b expected 0", res_valid);
    end
    kill = 1'b0; idle; step;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL kill_dropped: got %b expected 0", res_valid);
    end
    drive(3'b000, 32'h2, 32'h2, 32'h80, 32'h10, 1'b0); step;
    stall = 1'b1; kill = 1'b1; idle; step;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL kill_over_stall: got %b expected 0", res_valid);
    end
    stall = 1'b0; kill = 1'b0;
  endtask

  task automatic test_illegal;
    rst = 1'b1; idle; step; rst = 1'b0;
    fetch_pc = 32'h40;
    drive(3'b010, 32'h5, 32'h5, 32'h40, 32'h10, 1'b1); step;
    checks++;
    if (res_bus() !== {4'b1001, 32'h44}) begin
      errors++; $display("FAIL illegal_res: got %h expected %h", res_bus(), {4'b1001, 32'h44});
    end
    idle; step;
    drive(3'b000, 32'h1, 32'h1, 32'h40, 32'h10, 1'b0); step;
    idle; step;
    checks++;
    if (fetch_pred_taken !== PE) begin
      errors++; $display("FAIL illegal_no_train: got %b expected %b", fetch_pred_taken, PE);
    end
  endtask

  task automatic test_reset_mid;
    fetch_pc = 32'h40;
    drive(3'b000, 32'h1, 32'h1, 32'h40, 32'h10, 1'b0); step;
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got %b expected 1", res_valid);
    end
    rst = 1'b1; stall = 1'b1; step;
    checks++;
    if (res_bus() !== 36'h0) begin
      errors++; $display("FAIL midrst_outputs: got %h expected %h", res_bus(), 36'h0);
    end
    checks++;
    if (fetch_pred_taken !== 1'b0) begin
      errors++; $display("FAIL midrst_pred: got %b expected 0", fetch_pred_taken);
    end
    rst = 1'b0; stall = 1'b0;
    drive(3'b000, 32'h1, 32'h1, 32'h40, 32'h10, 1'b0); step;
    idle; step;
    checks++;
    if (fetch_pred_taken !== PE) begin
      errors++; $display("FAIL midrst_counter: got %b expected %b", fetch_pred_taken, PE);
    end
  endtask

  initial begin
    test_reset;
    test_bge_equal;
    test_compare_types;
    test_wrap;
    test_back_to_back;
    test_stall_kill;
    test_illegal;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
